// File: rtl/clk_div_pkg.sv
// Shared constants and state encoding for the multi-channel clock divider.
package clk_div_pkg;
  localparam int MIN_DIV   = 2;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow/active divisor, IDLE/RUN state,
// registered square wave and period-start tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clkout,
  output logic             tick,
  output logic             pend
);
  state_e           state;
  logic [CNT_W-1:0] cnt, div_act, div_shd;
  logic [CNT_W-1:0] cnt_nxt, half;
  logic             wrap;

  assign cnt_nxt = cnt + CNT_W'(1);
  // ceil(D/2) without widening: max divisor still fits
  assign half    = (div_act >> 1) + CNT_W'(div_act[0]);
  assign wrap    = (cnt == div_act - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      clkout  <= 1'b0;
      tick    <= 1'b0;
      div_act <= CNT_W'(DEFAULT_DIV);
      div_shd <= CNT_W'(DEFAULT_DIV);
      pend    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          div_act <= div_shd;
          pend    <= 1'b0;
          cnt     <= '0;
          if (en) begin
            state  <= RUN;
            tick   <= 1'b1;
            clkout <= 1'b1;
          end else begin
            tick   <= 1'b0;
            clkout <= 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            state  <= IDLE;
            cnt    <= '0;
            tick   <= 1'b0;
            clkout <= 1'b0;
          end else if (sync || wrap) begin
            cnt     <= '0;
            tick    <= 1'b1;
            clkout  <= 1'b1;
            div_act <= div_shd;
            pend    <= 1'b0;
          end else begin
            cnt    <= cnt_nxt;
            tick   <= 1'b0;
            clkout <= (cnt_nxt < half);
          end
        end
        default: state <= IDLE;
      endcase
      // a write landing with a divisor load stays pending for the next boundary
      if (wr) begin
        div_shd <= wr_div;
        pend    <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator: config decode,
// sticky error flag and sync fan-out around N_CH divider channels.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  clkout,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  cfg_pend,
  output logic             cfg_err
);
  localparam logic [3:0] N_CH_L = 4'(N_CH);

  logic ch_ok, div_ok, accept;

  assign ch_ok  = ({1'b0, cfg_ch} < N_CH_L);
  assign div_ok = (cfg_div >= CNT_W'(MIN_DIV));
  assign accept = cfg_wr && ch_ok && div_ok;

  always_ff @(posedge clk) begin
    if (reset)                 cfg_err <= 1'b0;
    else if (cfg_wr && !accept) cfg_err <= 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .en    (en[i]),
      .sync  (sync),
      .wr    (accept && (cfg_ch == 3'(i))),
      .wr_div(cfg_div),
      .clkout(clkout[i]),
      .tick  (tick[i]),
      .pend  (cfg_pend[i])
    );
  end
endmodule

// File: tb/tb_clk_div_gen.sv
// Randomized + directed bench for clk_div_gen against a period-position model.
module tb_clk_div_gen;
  localparam int N  = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  en;
  logic          sync, cfg_wr;
  logic [2:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic [N-1:0]  clkout, tick, cfg_pend;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;

  // model: whether running, position within current period, divisors, flags
  int     m_run [N];
  int     m_pos [N];
  int     m_dact[N];
  int     m_dshd[N];
  int     m_pend[N];
  int     m_err;

  clk_div_gen #(.N_CH(N), .CNT_W(CW), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clkout(clkout), .tick(tick),
    .cfg_pend(cfg_pend), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_pos[i] = 0; m_dact[i] = 4; m_dshd[i] = 4; m_pend[i] = 0;
      end
      m_err = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (!m_run[i]) begin
        m_dact[i] = m_dshd[i];
        m_pend[i] = 0;
        m_pos[i]  = 0;
        if (en[i]) m_run[i] = 1;
      end else if (!en[i]) begin
        m_run[i] = 0;
        m_pos[i] = 0;
      end else if (sync || m_pos[i] == m_dact[i] - 1) begin
        m_pos[i]  = 0;
        m_dact[i] = m_dshd[i];
        m_pend[i] = 0;
      end else begin
        m_pos[i]++;
      end
    end
    if (cfg_wr) begin
      if (int'(cfg_ch) < N && int'(cfg_div) >= 2) begin
        m_dshd[cfg_ch] = int'(cfg_div);
        m_pend[cfg_ch] = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_clk, e_tick, e_pend;
    for (int i = 0; i < N; i++) begin
      e_tick[i] = m_run[i] != 0 && m_pos[i] == 0;
      e_clk[i]  = m_run[i] != 0 && m_pos[i] < (m_dact[i] + 1) / 2;
      e_pend[i] = m_pend[i] != 0;
    end
    chk("clkout", 32'(clkout), 32'(e_clk));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("cfg_pend", 32'(cfg_pend), 32'(e_pend));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  // Apply one cycle of inputs, step the model with them, check just after the edge.
  task automatic cyc(input logic r, input logic [N-1:0] e, input logic s,
                     input logic w, input logic [2:0] ch, input logic [CW-1:0] d);
    reset = r; en = e; sync = s; cfg_wr = w; cfg_ch = ch; cfg_div = d;
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic idle_n(input int n, input logic [N-1:0] e);
    for (int k = 0; k < n; k++) cyc(1'b0, e, 1'b0, 1'b0, 3'd0, '0);
  endtask

  initial begin
    reset = 1'b1; en = '0; sync = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_dact[i] = 4; m_dshd[i] = 4; m_pend[i] = 0;
    end
    m_err = 0;
    cyc(1'b1, '0, 1'b0, 1'b0, 3'd0, '0);
    cyc(1'b1, '0, 1'b0, 1'b0, 3'd0, '0);
    chk("rst_clkout", 32'(clkout), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);

    // default divide-by-4 on ch0: 1100 pattern, tick every 4
    cyc(1'b0, 3'b001, 1'b0, 1'b0, 3'd0, '0);
    chk("first_tick", 32'(tick), 32'b001);
    idle_n(11, 3'b001);

    // ch1 idle write D=5, then enable
    cyc(1'b0, 3'b001, 1'b0, 1'b1, 3'd1, 16'd5);
    chk("pend_idle", 32'(cfg_pend[1]), 32'd1);
    idle_n(1, 3'b001);
    chk("pend_idle_clr", 32'(cfg_pend[1]), 32'd0);
    idle_n(12, 3'b011);

    // ch0 retune mid-period, then coincident with a wrap
    cyc(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, '0);
    idle_n(2, 3'b001);
    cyc(1'b0, 3'b001, 1'b0, 1'b1, 3'd0, 16'd6);
    idle_n(14, 3'b001);
    idle_n(3, 3'b001);
    cyc(1'b0, 3'b001, 1'b0, 1'b1, 3'd0, 16'd4);
    idle_n(14, 3'b001);

    // ch2 at D=6 alongside ch0, then sync
    cyc(1'b0, 3'b001, 1'b0, 1'b1, 3'd2, 16'd6);
    idle_n(7, 3'b101);
    cyc(1'b0, 3'b101, 1'b1, 1'b0, 3'd0, '0);
    chk("sync_tick", 32'(tick), 32'b101);
    idle_n(8, 3'b101);

    // illegal writes: sticky error, divisors unchanged
    cyc(1'b0, 3'b101, 1'b0, 1'b1, 3'd0, 16'd1);
    chk("err_div", 32'(cfg_err), 32'd1);
    cyc(1'b0, 3'b101, 1'b0, 1'b1, 3'd3, 16'd9);
    idle_n(6, 3'b101);
    chk("err_sticky", 32'(cfg_err), 32'd1);

    // D=7 then reset mid-period; resume at default 4
    cyc(1'b0, 3'b001, 1'b0, 1'b1, 3'd0, 16'd7);
    idle_n(10, 3'b001);
    cyc(1'b1, 3'b001, 1'b0, 1'b0, 3'd0, '0);
    chk("rst_mid", 32'({clkout, tick, cfg_err}), 32'd0);
    idle_n(10, 3'b001);

    // a larger divisor once
    cyc(1'b0, 3'b001, 1'b0, 1'b1, 3'd0, 16'd300);
    idle_n(700, 3'b001);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic [N-1:0] e;
      e = (k % 40 == 0) ? N'($urandom) : en;
      if ($urandom_range(0, 7) == 0) e = '1;
      cyc(($urandom_range(0, 299) == 0), e, ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 3)),
          16'($urandom_range(0, 9)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock-enable and divided-clock generator for the FSK/PCM datapath: it derives the bit-rate, sample-rate and carrier timing from the single system clock. Each channel has a runtime-programmable integer divisor, so the FSK mark/space carriers can be retuned without a rebuild. Divisor updates are glitch-free because they take effect only on a period boundary. A common sync strobe phase-aligns all channels. Each channel produces a registered square wave and a one-cycle tick strobe for downstream clock enables.

## Interface
- N_CH, 3: number of independent divider channels (1..8)
- CNT_W, 16: counter/divisor width in bits
- DEFAULT_DIV, 4: divisor loaded into every channel at reset (≥2; 4 gives the legacy divide-by-4, 50% duty)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  N_CH  per-channel run enable
- sync  in  1  restart all enabled channels in phase
- cfg_wr  in  1  divisor write strobe, one cycle
- cfg_ch  in  3  target channel index for cfg_wr
- cfg_div  in  CNT_W  new divisor D
- clkout  out  N_CH  divided square wave per channel
- tick  out  N_CH  one-cycle pulse at the start of each period
- cfg_pend  out  N_CH  written divisor not yet applied
- cfg_err  out  1  sticky illegal-write flag

## Operation
- Per-channel registers:
  - cnt (CNT_W): position in the period, 0..D-1
  - div_act: divisor in use
  - div_shd: shadow divisor
  - running, clkout, tick
- Period semantics for active divisor D:
  - Period is D cycles.
  - clkout = 1 while cnt < ceil(D/2), else 0. Even D gives exactly 50% duty; odd D is high one cycle longer than low.
  - tick = 1 exactly when cnt == 0.
- Per-channel state machine with two states:
  - IDLE (running=0): cnt=0, clkout=0, tick=0.
  - IDLE→RUN when en[i]=1: next edge loads cnt=0, tick=1, clkout=1, and div_act=div_shd.
  - RUN→IDLE when en[i]=0: next edge returns the channel to IDLE values.
- In RUN:
  - cnt increments each cycle.
  - When cnt == div_act-1, next edge sets cnt=0 and div_act=div_shd; this is the wrap.
- Configuration write (cfg_wr=1):
  - Accepted if cfg_ch < N_CH and cfg_div ≥ 2.
  - If accepted, div_shd[cfg_ch] ← cfg_div and cfg_pend[cfg_ch] ← 1.
  - If rejected, no state changes except cfg_err ← 1.
- cfg_pend clears on the edge where div_act takes div_shd, whether by wrap, sync or IDLE→RUN.
- A channel in IDLE copies div_shd into div_act on the cycle after the write.
- sync=1 acts on every channel in RUN: next edge sets cnt=0, tick=1, clkout=1 and div_act=div_shd. IDLE channels ignore sync.
- Priority, highest first: reset > en low > sync > wrap > count.
- Simultaneous cfg_wr and wrap on the same channel: the wrap loads the old div_shd, the new value lands in div_shd and stays pending until the next wrap.
- Reset mid-operation: every channel returns to IDLE; div_act = div_shd = DEFAULT_DIV; cfg_pend = 0; cfg_err = 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reset values: clkout=0, tick=0, cfg_pend=0, cfg_err=0.
- Latency from en rising (sampled at edge t) to first tick/clkout high: the edge at t. Outputs are visible in cycle t+1.
- Subsequent ticks follow every D cycles.
- Latency from sync sampled to tick: 1 cycle.
- Latency from cfg_wr sampled to cfg_pend high: 1 cycle.
- Latency from cfg_wr sampled to cfg_err high: 1 cycle.
- A new divisor affects output no earlier than the next period start; there are no runt pulses.
- D = 2^CNT_W−1 must count without overflow.

## Structure
- Package clk_div_pkg holds:
  - MIN_DIV = 2
  - default CNT_W
  - the state encoding enum {IDLE, RUN}
- Sub-module clk_div_chan contains one channel: counter, shadow/active divisor, state, clkout and tick. It is instantiated N_CH times in a generate loop.
- The top level contains only cfg_wr/cfg_ch decode, cfg_err, and fan-out of sync.

## Test plan
- After reset, en=3'b001 with D=4: clkout[0] pattern 1100 repeating. tick[0] is high on cycles 1, 5, 9. Other channels stay 0.
- Write D=5 to ch1 while it is idle, then enable: clkout 11100 repeating, tick every 5 cycles, cfg_pend[1] clears 1 cycle after the write.
- Ch0 running at D=4: write D=6 at cnt=1. The current period completes at 4 cycles and the next is 6 cycles (111000). cfg_pend is high until that wrap. Repeat with cfg_wr coincident with the wrap: new D applies one period later.
- Ch0 at D=4 and ch2 at D=6, both running: assert sync. Both tick on the next cycle and both clkout rise together.
- Illegal writes: cfg_div=1 and cfg_ch=3 with N_CH=3. No divisor changes, cfg_err=1 and sticky. Reset then clears cfg_err.
- Assert reset mid-period at D=7: outputs are 0 in the next cycle. After reset releases with en high, operation resumes at D=4, not 7.
